// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex seven-segment scanner with frame snapshot, leading-zero
// suppression, blank mask, PWM dimming and guard cycle. Optional decimal point: SEVEN_SEG_DP_EN.
module seven_segment_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int COUNT_TO   = 100000,
    parameter int DUTY_BITS  = 3
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [4*NUM_DIGITS-1:0]   val_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      lz_en_in,
    input  logic [DUTY_BITS-1:0]      bright_in,
`ifdef SEVEN_SEG_DP_EN
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic                      dp_out,
`endif
    output logic [6:0]                cat_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_start_out
);

    localparam int TW = $clog2(COUNT_TO);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [TW-1:0]            r_tick_cnt;
    logic [DW-1:0]            r_digit_idx;
    logic [DUTY_BITS-1:0]     r_pwm_cnt;
    logic [4*NUM_DIGITS-1:0]  r_frame_val;
    logic [NUM_DIGITS-1:0]    r_frame_blank;
    logic                     r_frame_lz;
    logic [DUTY_BITS-1:0]     r_frame_bright;
    logic [6:0]               r_cat;
    logic [NUM_DIGITS-1:0]    r_an;
    logic                     r_frame_start;

    logic                     w_tick_wrap;
    logic                     w_snap;
    logic [NUM_DIGITS-1:0]    w_sel;
    logic [NUM_DIGITS-1:0]    w_nib_nz;
    logic [NUM_DIGITS-1:0]    w_lz_sup;
    logic [NUM_DIGITS-1:0]    w_dblank_vec;
    logic [3:0]               w_nibble;
    logic                     w_dblank;
    logic                     w_lit;
    logic [6:0]               w_seg;

`ifdef SEVEN_SEG_DP_EN
    logic [NUM_DIGITS-1:0]    r_frame_dp;
    logic                     r_dp;
    logic                     w_dp;
`endif

    function automatic logic [6:0] hex7seg(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h00;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign w_tick_wrap = (r_tick_cnt == TW'(COUNT_TO - 1));
    assign w_snap      = (r_tick_cnt == '0) && (r_digit_idx == '0);

    // Per-digit decode: select line, and LZ suppression when this nibble and all above are zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_sel[gi]    = (r_digit_idx == DW'(gi));
            assign w_nib_nz[gi] = |r_frame_val[4*gi +: 4];
            if (gi == 0) begin : g_first
                assign w_lz_sup[gi] = 1'b0;
            end else begin : g_upper
`ifdef SEVEN_SEG_DP_EN
                assign w_lz_sup[gi] = r_frame_lz && !(|w_nib_nz[NUM_DIGITS-1:gi]) && !r_frame_dp[gi];
`else
                assign w_lz_sup[gi] = r_frame_lz && !(|w_nib_nz[NUM_DIGITS-1:gi]);
`endif
            end
            assign w_dblank_vec[gi] = r_frame_blank[gi] | w_lz_sup[gi];
        end
    endgenerate

    always_comb begin
        w_nibble = 4'h0;
        w_dblank = 1'b0;
`ifdef SEVEN_SEG_DP_EN
        w_dp     = 1'b0;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
                w_nibble = r_frame_val[4*i +: 4];
                w_dblank = w_dblank_vec[i];
`ifdef SEVEN_SEG_DP_EN
                w_dp     = r_frame_dp[i];
`endif
            end
        end
    end

    // Tick 0 of every slot is a dark guard cycle so the previous digit's anode is off before the next one.
    assign w_lit = (r_tick_cnt != '0) && !w_dblank && (r_pwm_cnt <= r_frame_bright);
    assign w_seg = hex7seg(w_nibble);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tick_cnt     <= '0;
            r_digit_idx    <= '0;
            r_pwm_cnt      <= '0;
            r_frame_val    <= '0;
            r_frame_blank  <= '0;
            r_frame_lz     <= 1'b0;
            r_frame_bright <= '0;
            r_cat          <= 7'h7F;
            r_an           <= '1;
            r_frame_start  <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_tick_wrap) begin
                r_tick_cnt <= '0;
                if (r_digit_idx == DW'(NUM_DIGITS - 1)) begin
                    r_digit_idx <= '0;
                end else begin
                    r_digit_idx <= r_digit_idx + 1'b1;
                end
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            if (w_snap) begin
                r_frame_val    <= val_in;
                r_frame_blank  <= blank_in;
                r_frame_lz     <= lz_en_in;
                r_frame_bright <= bright_in;
            end
            r_frame_start <= w_snap;

            r_an  <= w_lit ? ~w_sel : '1;
            r_cat <= w_lit ? ~w_seg : 7'h7F;
        end
    end

`ifdef SEVEN_SEG_DP_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_frame_dp <= '0;
            r_dp       <= 1'b1;
        end else begin
            if (w_snap) begin
                r_frame_dp <= dp_in;
            end
            r_dp <= ~(w_lit & w_dp);
        end
    end

    assign dp_out = r_dp;
`endif

    assign cat_out         = r_cat;
    assign an_out          = r_an;
    assign frame_start_out = r_frame_start;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Table-driven check of seven_segment_scanner with NUM_DIGITS=4, COUNT_TO=4, DUTY_BITS=2;
// defining SEVEN_SEG_DP_EN also exercises the decimal point.
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] val;
    logic [3:0]  blank;
    logic        lz;
    logic [1:0]  bright;
    logic [6:0]  cat;
    logic [3:0]  an;
    logic        fs;
`ifdef SEVEN_SEG_DP_EN
    logic [3:0]  dp;
    logic        dp_o;
`endif

    int checks   = 0;
    int failures = 0;

    seven_segment_scanner #(
        .NUM_DIGITS (4),
        .COUNT_TO   (4),
        .DUTY_BITS  (2)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .val_in          (val),
        .blank_in        (blank),
        .lz_en_in        (lz),
        .bright_in       (bright),
`ifdef SEVEN_SEG_DP_EN
        .dp_in           (dp),
        .dp_out          (dp_o),
`endif
        .cat_out         (cat),
        .an_out          (an),
        .frame_start_out (fs)
    );

    always #5 clk = ~clk;

    // One frame of stimulus plus the anode/segment pattern each digit shows whenever it is lit.
    typedef struct {
        logic [15:0] val;
        logic [3:0]  blank;
        logic        lz;
        logic [1:0]  bright;
        logic [3:0]  dp;
        logic        mid_en;
        logic [15:0] mid_val;
        logic [15:0] an_all;
        logic [27:0] cat_all;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(logic [15:0] v, logic [3:0] b, logic l, logic [1:0] br,
                                logic [3:0] d, logic me, logic [15:0] mv,
                                logic [15:0] a, logic [27:0] c);
        vec_t r;
        r.val = v; r.blank = b; r.lz = l; r.bright = br; r.dp = d;
        r.mid_en = me; r.mid_val = mv; r.an_all = a; r.cat_all = c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called on a falling edge where the DUT sits in the snapshot cycle; checks the 16 outputs of that frame.
    // With COUNT_TO == 2**DUTY_BITS and a common reset, pwm_cnt equals tick_cnt.
    task automatic run_frame(input vec_t v, input int idx);
        int d, t;
        logic lit;
        logic [3:0] an_d;
        logic [6:0] cat_d;
        val = v.val; blank = v.blank; lz = v.lz; bright = v.bright;
`ifdef SEVEN_SEG_DP_EN
        dp = v.dp;
`endif
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            d     = (k - 1) / 4;
            t     = (k - 1) % 4;
            an_d  = v.an_all[4*d +: 4];
            cat_d = v.cat_all[7*d +: 7];
            lit   = (t != 0) && (t <= int'(v.bright)) && (an_d != 4'hF);
            chk($sformatf("v%0d_k%0d_an", idx, k), an, lit ? an_d : 4'hF);
            chk($sformatf("v%0d_k%0d_cat", idx, k), cat, lit ? cat_d : 7'h7F);
            chk($sformatf("v%0d_k%0d_fs", idx, k), fs, (k == 1));
`ifdef SEVEN_SEG_DP_EN
            chk($sformatf("v%0d_k%0d_dp", idx, k), dp_o, (lit && v.dp[d]) ? 1'b0 : 1'b1);
`endif
            if (v.mid_en && k == 9) val = v.mid_val;
        end
        $display("frame vec=%0d val=%h blank=%b lz=%0d bright=%0d checks=%0d failures=%0d",
                 idx, v.val, v.blank, v.lz, v.bright, checks, failures);
    endtask

    initial begin
        int nv;
        int lit_cnt;

        vecs[0] = mk(16'h1234, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b1, 16'hABCD, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19});
        vecs[1] = mk(16'hABCD, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 16'h0000, 16'h7BDE, {7'h08, 7'h03, 7'h46, 7'h21});
        vecs[2] = mk(16'h0050, 4'b0000, 1'b1, 2'd3, 4'b0000, 1'b0, 16'h0000, 16'hFFDE, {7'h7F, 7'h7F, 7'h12, 7'h40});
        vecs[3] = mk(16'h0000, 4'b0000, 1'b1, 2'd3, 4'b0000, 1'b0, 16'h0000, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        vecs[4] = mk(16'h0000, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 16'h0000, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40});
        vecs[5] = mk(16'h1234, 4'b0101, 1'b0, 2'd3, 4'b0000, 1'b0, 16'h0000, 16'h7FDF, {7'h79, 7'h7F, 7'h30, 7'h7F});
        vecs[6] = mk(16'h0100, 4'b0000, 1'b1, 2'd3, 4'b0000, 1'b0, 16'h0000, 16'hFBDE, {7'h7F, 7'h79, 7'h40, 7'h40});
        vecs[7] = mk(16'h1234, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 16'h0000, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19});
        vecs[8] = mk(16'h1234, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 16'h0000, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19});
        vecs[9] = mk(16'h0000, 4'b0000, 1'b1, 2'd3, 4'b0010, 1'b0, 16'h0000, 16'hFFDE, {7'h7F, 7'h7F, 7'h40, 7'h40});
`ifdef SEVEN_SEG_DP_EN
        nv = 10;
        dp = 4'b0000;
`else
        nv = 9;
`endif

        rst = 1'b1; val = 16'h1234; blank = 4'b0000; lz = 1'b0; bright = 2'd3;
        repeat (2) @(negedge clk);
        chk("reset_an", an, 4'hF);
        chk("reset_cat", cat, 7'h7F);
        chk("reset_fs", fs, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < nv; i++) run_frame(vecs[i], i);

        // 64 cycles at bright=1: only tick 1 of each slot is lit, 16 digit slots in total.
        val = 16'h1234; blank = 4'b0000; lz = 1'b0; bright = 2'd1;
        lit_cnt = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (an !== 4'hF) lit_cnt++;
        end
        chk("pwm_lit_count", lit_cnt, 16);
        $display("pwm window lit=%0d", lit_cnt);

        // Asynchronous reset while a digit is lit, then restart from digit 0.
        bright = 2'd3;
        repeat (3) @(negedge clk);
        chk("pre_rst_an", an, 4'hE);
        chk("pre_rst_cat", cat, 7'h19);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_an", an, 4'hF);
        chk("async_rst_cat", cat, 7'h7F);
        chk("async_rst_fs", fs, 1'b0);
        @(negedge clk);
        chk("held_rst_an", an, 4'hF);
        rst = 1'b0;
        $display("mid-frame reset applied and released");
        run_frame(vecs[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
